ifetch_queue: RTL and testbench



---
 rtl/ifetch_pkg.sv | 15 +
 rtl/ifetch_queue_if.sv | 41 ++++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/ifetch_queue.sv | 100 ++++++++++
 tb/tb_ifetch_queue.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types for the instruction fetch queue.
// Holds default depth, queue entry layout and the empty entry.
package ifetch_pkg;

  localparam int DEPTH_DEF = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  localparam int     ENTRY_W     = $bits(entry_t);
  localparam entry_t ENTRY_EMPTY = '0;

endpackage

// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: PC input, imem read port and decode handshake.
// master = queue side, slave = PC unit / imem / decode side.
interface ifetch_queue_if
  import ifetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc_in;
  logic          pc_valid;
  logic          pc_ready;
  logic          flush;
  logic          imem_en;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_rdata;
  logic [31:0]   inst_out;
  logic [31:0]   inst_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic [CW-1:0] count;
  logic          align_err;

  modport master (
    input  pc_in, pc_valid, flush,
    input  imem_rdata, inst_ready,
    output pc_ready, imem_en, imem_addr,
    output inst_out, inst_pc, inst_valid,
    output count, align_err
  );

  modport slave (
    output pc_in, pc_valid, flush,
    output imem_rdata, inst_ready,
    input  pc_ready, imem_en, imem_addr,
    input  inst_out, inst_pc, inst_valid,
    input  count, align_err
  );

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: DEPTH x W circular buffer, sync clr and flush clear.
// Ports: clk, clr, flush, push/din, pop/dout, count; dout=0 when empty.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[tail_q] <= din;
  end

  assign dout  = (cnt_q != '0) ? mem_q[head_q] : '0;
  assign count = cnt_q;

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch addr -> 1-cycle imem -> queue -> decode.
// Ports: clk, clr (sync, active-high), bus (ifetch_queue_if.master); macro FETCH_ALIGN_CHK_EN.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input logic            clk,
  input logic            clr,
  ifetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = CW + 1;
  localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

  logic          pend_v_q, pend_v_d;
  logic [31:0]   pend_pc_q, pend_pc_d;
  logic          accept;
  logic          fetch;
  logic          push;
  logic          pop;
  logic [OW-1:0] occ;
  logic [CW-1:0] cnt;
  entry_t        din;
  entry_t        dout;

  // In-flight read reserves a slot, so no push ever hits a full queue.
  assign occ = {1'b0, cnt} + {{CW{1'b0}}, pend_v_q};

  assign bus.pc_ready = !clr && !bus.flush && (occ < DEPTH_C);
  assign accept       = bus.pc_valid && bus.pc_ready;

`ifdef FETCH_ALIGN_CHK_EN
  logic misal;
  logic align_err_q, align_err_d;

  assign misal = bus.pc_in[1:0] != 2'b00;
  assign fetch = accept && !misal;

  always_comb begin
    align_err_d = align_err_q;
    if (accept && misal) align_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) align_err_q <= 1'b0;
    else     align_err_q <= align_err_d;
  end

  assign bus.align_err = align_err_q;
`else
  assign fetch         = accept;
  assign bus.align_err = 1'b0;
`endif

  assign bus.imem_en   = fetch;
  assign bus.imem_addr = fetch ? {bus.pc_in[31:2], 2'b00} : '0;

  always_comb begin
    pend_v_d  = fetch;
    pend_pc_d = fetch ? bus.pc_in : pend_pc_q;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pend_v_q  <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      pend_v_q  <= pend_v_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // A return landing in the flush cycle is stale.
  assign push = pend_v_q && !bus.flush;
  assign pop  = bus.inst_valid && bus.inst_ready && !bus.flush;

  assign din = '{pc: pend_pc_q, inst: bus.imem_rdata};

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .flush (bus.flush),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (dout),
    .count (cnt)
  );

  assign bus.count      = cnt;
  assign bus.inst_valid = cnt != '0;
  assign bus.inst_out   = dout.inst;
  assign bus.inst_pc    = dout.pc;

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: scoreboard bench for ifetch_queue.
// Directed fetch, stream, full, flush, reset and alignment vectors.
module tb_ifetch_queue;
  import ifetch_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic clr;

  always #5 clk = ~clk;

  ifetch_queue_if #(.DEPTH(DEPTH)) bus ();

  ifetch_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int     pass_n = 0;
  int     tot_n  = 0;
  int     cy     = 0;
  int     n_acc  = 0;
  int     max_cnt = 0;
  entry_t exp_q[$];
  int     acc_cy[$];
  int     pop_cy[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C22_0004;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] pc);
    bit ok;
    ok = 1'b0;
    bus.pc_valid = 1'b1;
    bus.pc_in    = pc;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = bus.pc_ready;
      cyc();
    end
    bus.pc_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  always @(posedge clk) cy <= cy + 1;

  // Synchronous imem model: data the cycle after the strobe.
  always @(posedge clk)
    bus.imem_rdata <= bus.imem_en ? memf(bus.imem_addr) : 32'hDEAD_BEEF;

  // Accept logger: builds the expected entry from the stimulus.
  always @(negedge clk) begin
    if (bus.pc_valid && bus.pc_ready) begin
      n_acc++;
      acc_cy.push_back(cy);
`ifdef FETCH_ALIGN_CHK_EN
      if (bus.pc_in[1:0] == 2'b00)
        exp_q.push_back('{pc: bus.pc_in,
                          inst: memf({bus.pc_in[31:2], 2'b00})});
`else
      exp_q.push_back('{pc: bus.pc_in,
                        inst: memf({bus.pc_in[31:2], 2'b00})});
`endif
    end
  end

  // Monitor: compares every consumed head against the scoreboard.
  always @(negedge clk) begin
    if (!clr && int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
    if (!clr && !bus.flush && bus.inst_valid && bus.inst_ready) begin
      pop_cy.push_back(cy);
      if (exp_q.size() == 0) begin
        tot_n++;
        $display("FAIL pop_unexpected: got pc %h inst %h want none",
                 bus.inst_pc, bus.inst_out);
      end else begin
        entry_t e;
        e = exp_q.pop_front();
        chk("pop_pc", bus.inst_pc, e.pc);
        chk("pop_inst", bus.inst_out, e.inst);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    clr            = 1'b1;
    bus.pc_valid   = 1'b0;
    bus.pc_in      = '0;
    bus.flush      = 1'b0;
    bus.inst_ready = 1'b0;
    repeat (2) cyc();

    // Reset state, with a request held during clr
    bus.pc_valid = 1'b1;
    bus.pc_in    = 32'h40;
    @(negedge clk);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_inst", bus.inst_out, 32'd0);
    chk("rst_pc", bus.inst_pc, 32'd0);
    chk("rst_imem_en", 32'(bus.imem_en), 32'd0);
    chk("rst_imem_addr", bus.imem_addr, 32'd0);
    chk("rst_pc_ready", 32'(bus.pc_ready), 32'd0);
    chk("rst_align_err", 32'(bus.align_err), 32'd0);

    // Single fetch: accept cycle 1, valid cycle 3
    cyc();
    clr = 1'b0;
    @(negedge clk);
    chk("c1_pc_ready", 32'(bus.pc_ready), 32'd1);
    chk("c1_imem_en", 32'(bus.imem_en), 32'd1);
    chk("c1_imem_addr", bus.imem_addr, 32'h40);
    cyc();
    bus.pc_valid = 1'b0;
    @(negedge clk);
    chk("c2_valid", 32'(bus.inst_valid), 32'd0);
    cyc();
    @(negedge clk);
    chk("c3_valid", 32'(bus.inst_valid), 32'd1);
    chk("c3_inst", bus.inst_out, 32'h8C22_0004);
    chk("c3_pc", bus.inst_pc, 32'h40);
    chk("c3_count", 32'(bus.count), 32'd1);
    cyc();
    bus.inst_ready = 1'b1;
    cyc();
    @(negedge clk);
    chk("c5_empty", 32'(bus.inst_valid), 32'd0);
    cyc();

    // Streaming 16 PCs with decode always ready
    acc_cy.delete();
    pop_cy.delete();
    max_cnt = 0;
    for (int i = 0; i < 16; i++) send(32'(i * 4));
    repeat (4) cyc();
    chk("stream_accepts", 32'(acc_cy.size()), 32'd16);
    chk("stream_pops", 32'(pop_cy.size()), 32'd16);
    if (acc_cy.size() == 16 && pop_cy.size() == 16) begin
      chk("stream_latency", 32'(pop_cy[0] - acc_cy[0]), 32'd2);
      chk("stream_rate", 32'(pop_cy[15] - pop_cy[0]), 32'd15);
    end
    chk("stream_maxcnt_le2", (max_cnt <= 2) ? 32'd1 : 32'd0, 32'd1);

    // Backpressure: exactly DEPTH accepts, one pop frees one slot
    bus.inst_ready = 1'b0;
    base = n_acc;
    bus.pc_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.pc_in = 32'h1000 + 32'(4 * (n_acc - base));
      @(negedge clk);
      cyc();
    end
    chk("full_accepts", 32'(n_acc - base), 32'd4);
    @(negedge clk);
    chk("full_pc_ready", 32'(bus.pc_ready), 32'd0);
    chk("full_count", 32'(bus.count), 32'd4);
    cyc();
    bus.inst_ready = 1'b1;
    @(negedge clk);
    cyc();
    bus.inst_ready = 1'b0;
    begin
      int b2;
      b2 = n_acc;
      for (int k = 0; k < 6; k++) begin
        bus.pc_in = 32'h1000 + 32'(4 * (n_acc - base));
        @(negedge clk);
        cyc();
      end
      chk("refill_accepts", 32'(n_acc - b2), 32'd1);
    end
    @(negedge clk);
    chk("refill_count", 32'(bus.count), 32'd4);
    cyc();
    bus.pc_valid   = 1'b0;
    bus.inst_ready = 1'b1;
    repeat (6) cyc();
    chk("drain_count", 32'(bus.count), 32'd0);

    // Flush with an in-flight read
    bus.inst_ready = 1'b0;
    send(32'h300);
    send(32'h304);
    cyc();
    send(32'h100);
    bus.flush      = 1'b1;
    bus.inst_ready = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("flush_pre_count", 32'(bus.count), 32'd2);
    chk("flush_pc_ready", 32'(bus.pc_ready), 32'd0);
    cyc();
    bus.flush      = 1'b0;
    bus.inst_ready = 1'b0;
    bus.pc_valid   = 1'b1;
    bus.pc_in      = 32'h200;
    @(negedge clk);
    chk("flush_count", 32'(bus.count), 32'd0);
    chk("flush_valid", 32'(bus.inst_valid), 32'd0);
    chk("flush_accept", 32'(bus.pc_ready), 32'd1);
    cyc();
    bus.pc_valid = 1'b0;
    @(negedge clk);
    chk("flush_n3_valid", 32'(bus.inst_valid), 32'd0);
    cyc();
    @(negedge clk);
    chk("flush_n4_valid", 32'(bus.inst_valid), 32'd1);
    chk("flush_n4_pc", bus.inst_pc, 32'h200);
    cyc();
    bus.inst_ready = 1'b1;
    repeat (2) cyc();
    chk("flush_drained", 32'(bus.count), 32'd0);

    // Reset mid-stream with count=3 and a read in flight
    bus.inst_ready = 1'b0;
    send(32'h400);
    send(32'h404);
    send(32'h408);
    cyc();
    send(32'h500);
    clr = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("clr_pre_count", 32'(bus.count), 32'd3);
    cyc();
    clr = 1'b0;
    @(negedge clk);
    chk("clr_count", 32'(bus.count), 32'd0);
    chk("clr_valid", 32'(bus.inst_valid), 32'd0);
    chk("clr_inst", bus.inst_out, 32'd0);
    chk("clr_pc", bus.inst_pc, 32'd0);
    chk("clr_imem_en", 32'(bus.imem_en), 32'd0);
    chk("clr_pc_ready", 32'(bus.pc_ready), 32'd1);
    cyc();
    @(negedge clk);
    chk("clr_ret_ignored", 32'(bus.count), 32'd0);
    cyc();

    // Alignment check
    bus.inst_ready = 1'b1;
    bus.pc_valid   = 1'b1;
    bus.pc_in      = 32'h42;
    @(negedge clk);
    chk("mis_pc_ready", 32'(bus.pc_ready), 32'd1);
`ifdef FETCH_ALIGN_CHK_EN
    chk("mis_imem_en", 32'(bus.imem_en), 32'd0);
`else
    chk("mis_imem_en", 32'(bus.imem_en), 32'd1);
    chk("mis_imem_addr", bus.imem_addr, 32'h40);
`endif
    cyc();
    bus.pc_in = 32'h44;
    @(negedge clk);
`ifdef FETCH_ALIGN_CHK_EN
    chk("mis_align_err", 32'(bus.align_err), 32'd1);
`else
    chk("mis_align_err", 32'(bus.align_err), 32'd0);
`endif
    chk("al_imem_en", 32'(bus.imem_en), 32'd1);
    chk("al_imem_addr", bus.imem_addr, 32'h44);
    cyc();
    bus.pc_valid = 1'b0;
    repeat (4) cyc();
`ifdef FETCH_ALIGN_CHK_EN
    chk("mis_align_sticky", 32'(bus.align_err), 32'd1);
`else
    chk("mis_align_tied", 32'(bus.align_err), 32'd0);
`endif
    chk("end_count", 32'(bus.count), 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
